// File: rtl/uart_pkg.sv
// UART receive deserialiser shared types.
// Frame states and framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam int MIN_DIV_DEF = 4;
  localparam int FRAME_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchroniser.
// Also flags the idle-to-start falling edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  // shift the line through the sync chain; idle-high reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_s_d  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-1];
  assign o_fall = r_s_d & ~o_rx_s;

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive front end.
// Samples mid-bit and strobes good bytes to the FIFO.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = MIN_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] clk_div,
  output logic [7:0]       rx_data,
  output logic             rx_wr_en,
  output logic             rx_busy,
  input  logic             rx_finish,
  output logic             frame_err,
  output logic             overrun
);

  state_t           r_state;
  state_t           w_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_sh;
  logic [7:0]       r_data;
  logic             r_wr;
  logic             r_fe;
  logic             r_ovr;

  logic             w_rx_s;
  logic             w_fall;
  logic [DIV_W-1:0] w_div;
  logic             w_half;
  logic             w_last;
  logic             w_load;
  logic             w_clr;
  logic             w_shift;
  logic             w_wr;
  logic             w_fe;
  logic             w_ovr;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rx  (rx_i),
    .o_rx_s(w_rx_s),
    .o_fall(w_fall)
  );

  assign w_div  = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV)
                                              : clk_div;
  assign w_half = (r_cnt == (r_div >> 1));
  assign w_last = (r_cnt == (r_div - DIV_W'(1)));

  // next state and one-cycle control strobes
  always_comb begin
    w_nxt   = r_state;
    w_load  = 1'b0;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_wr    = 1'b0;
    w_fe    = 1'b0;
    w_ovr   = 1'b0;
    if (!rx_en) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fall) begin
            w_nxt  = START;
            w_load = 1'b1;
            w_clr  = 1'b1;
          end
        end
        START: begin
          if (w_half) begin
            w_clr = 1'b1;
            w_nxt = w_rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_last) begin
            w_shift = 1'b1;
            w_clr   = 1'b1;
            if (r_bit == 3'(FRAME_BITS - 1))
              w_nxt = STOP;
          end
        end
        STOP: begin
          if (w_last) begin
            if (w_rx_s) begin
              w_wr  = 1'b1;
              w_nxt = HOLD;
            end else begin
              w_fe  = 1'b1;
              w_nxt = BREAK;
            end
          end
        end
        BREAK: begin
          if (w_rx_s)
            w_nxt = IDLE;
        end
        HOLD: begin
          if (w_fall) begin
            w_ovr  = 1'b1;
            w_load = 1'b1;
            w_clr  = 1'b1;
            w_nxt  = START;
          end else if (rx_finish) begin
            w_nxt = IDLE;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // bit-time counter, divisor latch, bit index and shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else begin
      if (w_load)
        r_div <= w_div;
      if (w_clr || !rx_en)
        r_cnt <= '0;
      else if (r_state inside {START, DATA, STOP})
        r_cnt <= r_cnt + DIV_W'(1);
      else
        r_cnt <= '0;
      if (!rx_en || r_state != DATA)
        r_bit <= '0;
      else if (w_shift)
        r_bit <= r_bit + 3'd1;
      if (w_shift)
        r_sh[r_bit] <= w_rx_s;
    end
  end

  // output byte, strobes and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_wr   <= 1'b0;
      r_fe   <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_wr <= w_wr;
      r_fe <= w_fe;
      if (w_wr)
        r_data <= r_sh;
      if (!rx_en)
        r_ovr <= 1'b0;
      else if (w_ovr)
        r_ovr <= 1'b1;
    end
  end

  assign rx_data   = r_data;
  assign rx_wr_en  = r_wr;
  assign frame_err = r_fe;
  assign overrun   = r_ovr;
  assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Testbench for uart_rx_deser.
// Table of single frames plus hand-written corner sequences.
module tb_uart_rx_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        rx_i = 1'b1;
  logic        rx_finish = 1'b0;
  logic [15:0] clk_div = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_wr_en;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;

  always #5 clk = ~clk;

  uart_rx_deser dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_en    (rx_en),
    .rx_i     (rx_i),
    .clk_div  (clk_div),
    .rx_data  (rx_data),
    .rx_wr_en (rx_wr_en),
    .rx_busy  (rx_busy),
    .rx_finish(rx_finish),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int last_wr_cyc = 0;
  int t_fall = 0;
  bit fin_en = 1'b1;
  logic [7:0] wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record every write strobe and frame error pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_wr_en) begin
          wr_q.push_back(rx_data);
          last_wr_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
      end
    end
  end

  // FIFO model: acknowledge one cycle after the strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rx_wr_en && fin_en) begin
        @(negedge clk);
        rx_finish = 1'b1;
        @(negedge clk);
        rx_finish = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int qat(input int i);
    if (i < wr_q.size()) return int'(wr_q[i]);
    return -1;
  endfunction

  task automatic send(input logic [7:0] d, input logic stop,
                      input int bc);
    t_fall = cyc;
    rx_i = 1'b0;
    tick(bc);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(bc);
    end
    rx_i = stop;
    tick(bc);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    logic [15:0] div;
    int          bc;
    int          exp_wr;
    logic [7:0]  exp_d;
    int          exp_fe;
  } vec_t;

  vec_t tv[7];

  initial begin
    int wb;
    int fb;
    int h;

    tv[0] = '{8'hA5, 1'b1, 16'd16, 16, 1, 8'hA5, 0};
    tv[1] = '{8'h3C, 1'b0, 16'd16, 16, 0, 8'hA5, 1};
    tv[2] = '{8'h00, 1'b1, 16'd4,  4,  1, 8'h00, 0};
    tv[3] = '{8'hFF, 1'b1, 16'd7,  7,  1, 8'hFF, 0};
    tv[4] = '{8'h5A, 1'b1, 16'd2,  4,  1, 8'h5A, 0};
    tv[5] = '{8'h81, 1'b1, 16'd33, 33, 1, 8'h81, 0};
    tv[6] = '{8'hC3, 1'b0, 16'd5,  5,  0, 8'h81, 1};

    tick(3);
    chk("rst_busy", int'(rx_busy), 0);
    chk("rst_wr", int'(rx_wr_en), 0);
    chk("rst_fe", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_data", int'(rx_data), 0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    tick(5);

    for (int v = 0; v < 7; v++) begin
      wb = wr_q.size();
      fb = fe_cnt;
      clk_div = tv[v].div;
      send(tv[v].d, tv[v].stop, tv[v].bc);
      if (!tv[v].stop) begin
        tick(3 * tv[v].bc);
        chk($sformatf("v%0d_break_busy", v), int'(rx_busy), 1);
        rx_i = 1'b1;
      end
      tick(2 * tv[v].bc + 12);
      chk($sformatf("v%0d_wr", v), wr_q.size() - wb, tv[v].exp_wr);
      chk($sformatf("v%0d_data", v), int'(rx_data), int'(tv[v].exp_d));
      chk($sformatf("v%0d_fe", v), fe_cnt - fb, tv[v].exp_fe);
      chk($sformatf("v%0d_busy", v), int'(rx_busy), 0);
      if (tv[v].exp_wr == 1) begin
        h = tv[v].bc / 2;
        chk_rng($sformatf("v%0d_lat", v), last_wr_cyc - t_fall,
                3 + h + 9 * tv[v].bc, 5 + h + 9 * tv[v].bc);
      end
    end

    // short low glitch is a false start
    wb = wr_q.size();
    fb = fe_cnt;
    clk_div = 16'd16;
    rx_i = 1'b0;
    tick(5);
    chk("glitch_busy", int'(rx_busy), 1);
    rx_i = 1'b1;
    tick(40);
    chk("glitch_wr", wr_q.size() - wb, 0);
    chk("glitch_fe", fe_cnt - fb, 0);
    chk("glitch_idle", int'(rx_busy), 0);

    // back-to-back frames, no idle gap
    wb = wr_q.size();
    clk_div = 16'd10;
    send(8'h00, 1'b1, 10);
    send(8'hFF, 1'b1, 10);
    send(8'h55, 1'b1, 10);
    tick(40);
    chk("b2b_cnt", wr_q.size() - wb, 3);
    chk("b2b_0", qat(wb), 'h00);
    chk("b2b_1", qat(wb + 1), 'hFF);
    chk("b2b_2", qat(wb + 2), 'h55);
    chk("b2b_ovr", int'(overrun), 0);

    // no acknowledge: second start in HOLD raises overrun
    fin_en = 1'b0;
    wb = wr_q.size();
    clk_div = 16'd16;
    send(8'hA3, 1'b1, 16);
    tick(20);
    chk("hold_busy", int'(rx_busy), 1);
    chk("hold_ovr0", int'(overrun), 0);
    send(8'h6E, 1'b1, 16);
    tick(40);
    chk("ovr_cnt", wr_q.size() - wb, 2);
    chk("ovr_b0", qat(wb), 'hA3);
    chk("ovr_b1", qat(wb + 1), 'h6E);
    chk("ovr_set", int'(overrun), 1);
    rx_en = 1'b0;
    tick(2);
    chk("ovr_clr", int'(overrun), 0);
    chk("dis_busy", int'(rx_busy), 0);
    rx_en = 1'b1;
    fin_en = 1'b1;
    tick(5);

    // disable mid-frame aborts without a write
    wb = wr_q.size();
    clk_div = 16'd8;
    rx_i = 1'b0;
    tick(30);
    rx_en = 1'b0;
    tick(1);
    chk("abort_busy", int'(rx_busy), 0);
    rx_en = 1'b1;
    rx_i = 1'b1;
    tick(100);
    chk("abort_wr", wr_q.size() - wb, 0);

    // async reset mid-frame, then a frame at clk_div=2
    wb = wr_q.size();
    clk_div = 16'd16;
    rx_i = 1'b0;
    tick(16);
    rx_i = 1'b1;
    tick(16);
    rx_i = 1'b0;
    tick(48);
    tick(8);
    rst_n = 1'b0;
    tick(1);
    chk("ar_busy", int'(rx_busy), 0);
    chk("ar_data", int'(rx_data), 0);
    chk("ar_ovr", int'(overrun), 0);
    chk("ar_wr", int'(rx_wr_en), 0);
    rx_i = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    clk_div = 16'd2;
    send(8'h42, 1'b1, 4);
    tick(30);
    chk("ar_cnt", wr_q.size() - wb, 1);
    chk("ar_byte", qat(wb), 'h42);
    chk_rng("ar_lat", last_wr_cyc - t_fall, 41, 43);
    chk("ar_idle", int'(rx_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
